alarm_controller: RTL and testbench

Decides when the alarm sounds and drives the level `o_Alarm_On` into the downstream buzzer/blink toggler. It compares the running time-of-day against the stored alarm time and raises the alarm once per match. It also handles snooze, dismiss and auto-timeout, paced by the one-second tick from the timekeeping counter.

---
 rtl/alarm_pkg.sv | 23 ++
 rtl/countdown_timer.sv | 31 +++
 rtl/alarm_controller.sv | 156 +++++++++++++++
 tb/tb_alarm_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared alarm definitions: state encoding, time-field widths, small helpers.
// Latency: none (definitions only).
// Backpressure: none.
package alarm_pkg;

    // Time-of-day field widths, shared with the timekeeping and alarm-set blocks
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    // Alarm controller state encoding
    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] alarm_state_t;

    localparam alarm_state_t IDLE    = 2'd0;
    localparam alarm_state_t RINGING = 2'd1;
    localparam alarm_state_t SNOOZED = 2'd2;

    // Larger of two integers, used to size the shared countdown
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter advanced by a tick enable, flags the tick that lands on 1.
// Latency: load/decrement visible next cycle; o_Expire is combinational from the tick.
// Backpressure: none; load and tick are accepted every cycle, load wins over tick.
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Load_Value,
    input  logic             i_Tick,
    output logic             o_Expire
);

    logic [WIDTH-1:0] count;

    // Expiry is the tick that consumes the final remaining unit
    assign o_Expire = i_Tick && (count == WIDTH'(1));

    // Load has priority; decrement saturates at zero so the count never wraps
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            count <= '0;
        end else if (i_Load) begin
            count <= i_Load_Value;
        end else if (i_Tick && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencer: edge-detects the alarm-time match, then rings / snoozes / times out.
// Latency: one cycle from trigger, snooze, dismiss or final tick to the registered outputs.
// Backpressure: none; all control pulses are single-cycle and are consumed when seen.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SECONDS       = 540,
    parameter int RING_TIMEOUT_SECONDS = 300,
    parameter int MAX_SNOOZES          = 3
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Sec_Tick,
    input  logic [HOUR_W-1:0] i_Hour,
    input  logic [MIN_W-1:0]  i_Minute,
    input  logic [HOUR_W-1:0] i_Alarm_Hour,
    input  logic [MIN_W-1:0]  i_Alarm_Minute,
    input  logic              i_Alarm_Enable,
    input  logic              i_Snooze,
    input  logic              i_Dismiss,
    output logic              o_Alarm_On,
    output logic              o_Snoozed,
    output logic [2:0]        o_Snooze_Count
);

    // One counter covers both intervals because RINGING and SNOOZED never overlap
    localparam int CNT_W = $clog2(max_int(SNOOZE_SECONDS, RING_TIMEOUT_SECONDS) + 1);

    localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_TIMEOUT_SECONDS);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECONDS);
    localparam logic [2:0]       SNOOZE_MAX  = 3'(MAX_SNOOZES);

    logic match_now;
    logic match_q;
    logic trigger;

    alarm_state_t state;
    alarm_state_t next_state;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_tick;
    logic             cnt_expire;

    logic       snooze_clear;
    logic       snooze_inc;
    logic       alarm_on_d;
    logic       snoozed_d;
    logic [2:0] snooze_count_d;

    // A trigger is the first cycle of a match, so one matching minute rings once.
    // Enabling part-way through a match sees no edge and stays quiet.
    assign match_now = (i_Hour == i_Alarm_Hour) && (i_Minute == i_Alarm_Minute);
    assign trigger   = match_now && !match_q && i_Alarm_Enable;

    // Countdown only runs while an alarm event is in progress
    assign cnt_tick = i_Sec_Tick && ((state == RINGING) || (state == SNOOZED));

    // Match history; reset high so releasing reset during a matching minute stays silent
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            match_q <= 1'b1;
        end else begin
            match_q <= match_now;
        end
    end

    countdown_timer #(
        .WIDTH (CNT_W)
    ) u_countdown (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Load       (cnt_load),
        .i_Load_Value (cnt_load_value),
        .i_Tick       (cnt_tick),
        .o_Expire     (cnt_expire)
    );

    // State, snooze count and registered outputs
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state          <= IDLE;
            o_Alarm_On     <= 1'b0;
            o_Snoozed      <= 1'b0;
            o_Snooze_Count <= 3'd0;
        end else begin
            state          <= next_state;
            o_Alarm_On     <= alarm_on_d;
            o_Snoozed      <= snoozed_d;
            o_Snooze_Count <= snooze_count_d;
        end
    end

    // Next state and countdown control; event priority is
    // enable-low, dismiss, snooze, expiry, trigger
    always_comb begin
        next_state     = state;
        cnt_load       = 1'b0;
        cnt_load_value = RING_LOAD;
        snooze_clear   = 1'b0;
        snooze_inc     = 1'b0;

        if (!i_Alarm_Enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        next_state     = RINGING;
                        cnt_load       = 1'b1;
                        cnt_load_value = RING_LOAD;
                        snooze_clear   = 1'b1;
                    end
                end
                RINGING: begin
                    if (i_Dismiss) begin
                        next_state = IDLE;
                    end else if (i_Snooze && (o_Snooze_Count < SNOOZE_MAX)) begin
                        next_state     = SNOOZED;
                        cnt_load       = 1'b1;
                        cnt_load_value = SNOOZE_LOAD;
                        snooze_inc     = 1'b1;
                    end else if (cnt_expire) begin
                        next_state = IDLE;
                    end
                end
                SNOOZED: begin
                    // Snooze presses and fresh triggers are deliberately ignored here
                    if (i_Dismiss) begin
                        next_state = IDLE;
                    end else if (cnt_expire) begin
                        next_state     = RINGING;
                        cnt_load       = 1'b1;
                        cnt_load_value = RING_LOAD;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track the state register
    always_comb begin
        alarm_on_d     = (next_state == RINGING);
        snoozed_d      = (next_state == SNOOZED);
        snooze_count_d = o_Snooze_Count;
        if (snooze_clear) begin
            snooze_count_d = 3'd0;
        end else if (snooze_inc) begin
            snooze_count_d = o_Snooze_Count + 3'd1;
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus a randomized run against a reference model.
// Latency: outputs checked 1 time unit after each rising clock edge.
// Backpressure: none.
module tb_alarm_controller;

    localparam int SNZ   = 5;
    localparam int RING  = 4;
    localparam int MAXS  = 2;

    localparam int MD_OFF  = 0;
    localparam int MD_RING = 1;
    localparam int MD_NAP  = 2;

    logic       clk;
    logic       rst;
    logic       sec_tick;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_minute;
    logic       alarm_enable;
    logic       snooze;
    logic       dismiss;
    logic       alarm_on;
    logic       snoozed;
    logic [2:0] snooze_count;

    int n_vec;
    int n_bad;

    // Reference model: what the alarm is doing, how many ticks remain, snoozes used
    int m_mode;
    int m_left;
    int m_cnt;
    bit m_prev_match;

    alarm_controller #(
        .SNOOZE_SECONDS       (SNZ),
        .RING_TIMEOUT_SECONDS (RING),
        .MAX_SNOOZES          (MAXS)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Sec_Tick     (sec_tick),
        .i_Hour         (hour),
        .i_Minute       (minute),
        .i_Alarm_Hour   (alarm_hour),
        .i_Alarm_Minute (alarm_minute),
        .i_Alarm_Enable (alarm_enable),
        .i_Snooze       (snooze),
        .i_Dismiss      (dismiss),
        .o_Alarm_On     (alarm_on),
        .o_Snoozed      (snoozed),
        .o_Snooze_Count (snooze_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode       = MD_OFF;
        m_left       = 0;
        m_cnt        = 0;
        m_prev_match = 1'b1;
    endtask

    // One clock of alarm behaviour, evaluated from the inputs present at the edge
    task automatic model_update();
        bit match;
        bit fresh;
        bit live_tick;
        bit run_out;
        int nmode;
        int nleft;
        int ncnt;
        match     = (hour == alarm_hour) && (minute == alarm_minute);
        fresh     = match && !m_prev_match && alarm_enable;
        live_tick = sec_tick && (m_mode != MD_OFF);
        run_out   = live_tick && (m_left == 1);
        nmode     = m_mode;
        ncnt      = m_cnt;
        nleft     = (live_tick && m_left > 0) ? m_left - 1 : m_left;
        if (!alarm_enable) begin
            nmode = MD_OFF;
        end else if (m_mode == MD_RING) begin
            if (dismiss) nmode = MD_OFF;
            else if (snooze && m_cnt < MAXS) begin
                nmode = MD_NAP;
                nleft = SNZ;
                ncnt  = m_cnt + 1;
            end else if (run_out) nmode = MD_OFF;
        end else if (m_mode == MD_NAP) begin
            if (dismiss) nmode = MD_OFF;
            else if (run_out) begin
                nmode = MD_RING;
                nleft = RING;
            end
        end else if (fresh) begin
            nmode = MD_RING;
            nleft = RING;
            ncnt  = 0;
        end
        m_mode       = nmode;
        m_left       = nleft;
        m_cnt        = ncnt;
        m_prev_match = match;
    endtask

    // Apply one cycle of pulses, advance the model at the edge, sample just after it
    task automatic step(input bit t, input bit s, input bit d);
        sec_tick = t;
        snooze   = s;
        dismiss  = d;
        @(posedge clk);
        model_update();
        #1;
        sec_tick = 1'b0;
        snooze   = 1'b0;
        dismiss  = 1'b0;
    endtask

    // Start a fresh alarm event at 07:30 by moving the alarm time onto the current time
    task automatic arm_ring();
        hour         = 5'd7;
        minute       = 6'd30;
        alarm_hour   = 5'd7;
        alarm_minute = 6'd10;
        step(0, 0, 0);
        alarm_minute = 6'd30;
        step(0, 0, 0);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        sec_tick     = 1'b0;
        snooze       = 1'b0;
        dismiss      = 1'b0;
        hour         = 5'd7;
        minute       = 6'd30;
        alarm_hour   = 5'd7;
        alarm_minute = 6'd30;
        alarm_enable = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (alarm_on !== 1'b0 || snoozed !== 1'b0 || snooze_count !== 3'd0) begin
            $display("FAIL reset_values: on=%b snz=%b cnt=%0d, want 0/0/0", alarm_on, snoozed, snooze_count);
            n_bad++;
        end
        rst = 1'b0;
        repeat (3) step(1, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b0) begin
            $display("FAIL reset_release_match: on=%b, want 0", alarm_on);
            n_bad++;
        end
    endtask

    task automatic test_basic_ring();
        minute = 6'd29;
        step(0, 0, 0);
        minute = 6'd30;
        step(0, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b1) begin
            $display("FAIL basic_rise: on=%b, want 1", alarm_on);
            n_bad++;
        end
        for (int i = 0; i < RING - 1; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        n_vec++;
        if (alarm_on !== 1'b1) begin
            $display("FAIL basic_before_last_tick: on=%b, want 1", alarm_on);
            n_bad++;
        end
        step(1, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b0) begin
            $display("FAIL basic_timeout: on=%b, want 0", alarm_on);
            n_bad++;
        end
        repeat (6) step(1, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b0 || snoozed !== 1'b0) begin
            $display("FAIL basic_no_retrigger: on=%b snz=%b, want 0/0", alarm_on, snoozed);
            n_bad++;
        end
    endtask

    task automatic test_snooze_limit();
        arm_ring();
        n_vec++;
        if (alarm_on !== 1'b1 || snooze_count !== 3'd0) begin
            $display("FAIL edit_trigger: on=%b cnt=%0d, want 1/0", alarm_on, snooze_count);
            n_bad++;
        end
        step(0, 1, 0);
        n_vec++;
        if (alarm_on !== 1'b0 || snoozed !== 1'b1 || snooze_count !== 3'd1) begin
            $display("FAIL snooze1: on=%b snz=%b cnt=%0d, want 0/1/1", alarm_on, snoozed, snooze_count);
            n_bad++;
        end
        repeat (SNZ - 1) step(1, 0, 0);
        n_vec++;
        if (snoozed !== 1'b1 || alarm_on !== 1'b0) begin
            $display("FAIL snooze1_hold: on=%b snz=%b, want 0/1", alarm_on, snoozed);
            n_bad++;
        end
        step(1, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b1 || snoozed !== 1'b0) begin
            $display("FAIL snooze1_resume: on=%b snz=%b, want 1/0", alarm_on, snoozed);
            n_bad++;
        end
        step(0, 1, 0);
        repeat (SNZ) step(1, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b1 || snooze_count !== 3'd2) begin
            $display("FAIL snooze2_resume: on=%b cnt=%0d, want 1/2", alarm_on, snooze_count);
            n_bad++;
        end
        step(0, 1, 0);
        n_vec++;
        if (alarm_on !== 1'b1 || snoozed !== 1'b0 || snooze_count !== 3'd2) begin
            $display("FAIL snooze_limit: on=%b snz=%b cnt=%0d, want 1/0/2", alarm_on, snoozed, snooze_count);
            n_bad++;
        end
        step(0, 0, 1);
    endtask

    task automatic test_dismiss_vs_snooze();
        arm_ring();
        n_vec++;
        if (snooze_count !== 3'd0) begin
            $display("FAIL new_event_clears_count: cnt=%0d, want 0", snooze_count);
            n_bad++;
        end
        step(0, 1, 1);
        n_vec++;
        if (alarm_on !== 1'b0 || snoozed !== 1'b0 || snooze_count !== 3'd0) begin
            $display("FAIL dismiss_over_snooze: on=%b snz=%b cnt=%0d, want 0/0/0", alarm_on, snoozed, snooze_count);
            n_bad++;
        end
    endtask

    task automatic test_tick_with_snooze();
        arm_ring();
        step(1, 1, 0);
        repeat (SNZ - 1) step(1, 0, 0);
        n_vec++;
        if (snoozed !== 1'b1 || alarm_on !== 1'b0) begin
            $display("FAIL tick_snooze_hold: on=%b snz=%b, want 0/1", alarm_on, snoozed);
            n_bad++;
        end
        step(1, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b1) begin
            $display("FAIL tick_snooze_resume: on=%b, want 1", alarm_on);
            n_bad++;
        end
        step(0, 0, 1);
    endtask

    task automatic test_disable();
        arm_ring();
        step(0, 1, 0);
        alarm_enable = 1'b0;
        step(0, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b0 || snoozed !== 1'b0) begin
            $display("FAIL disable_snoozed: on=%b snz=%b, want 0/0", alarm_on, snoozed);
            n_bad++;
        end
        alarm_enable = 1'b1;
        repeat (3) step(1, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b0) begin
            $display("FAIL reenable_same_minute: on=%b, want 0", alarm_on);
            n_bad++;
        end
    endtask

    task automatic test_async_reset();
        arm_ring();
        step(0, 1, 0);
        repeat (SNZ) step(1, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b1 || snooze_count !== 3'd1) begin
            $display("FAIL pre_reset_ring: on=%b cnt=%0d, want 1/1", alarm_on, snooze_count);
            n_bad++;
        end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (alarm_on !== 1'b0 || snoozed !== 1'b0 || snooze_count !== 3'd0) begin
            $display("FAIL async_reset: on=%b snz=%b cnt=%0d, want 0/0/0", alarm_on, snoozed, snooze_count);
            n_bad++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) step(0, 0, 0);
        n_vec++;
        if (alarm_on !== 1'b0) begin
            $display("FAIL post_reset_match: on=%b, want 0", alarm_on);
            n_bad++;
        end
    endtask

    task automatic test_random();
        bit t;
        bit s;
        bit d;
        hour         = 5'd7;
        alarm_hour   = 5'd7;
        alarm_minute = 6'd30;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) minute = 6'(29 + $urandom_range(0, 2));
            if ($urandom_range(0, 39) == 0) alarm_minute = 6'(29 + $urandom_range(0, 2));
            if ($urandom_range(0, 59) == 0) hour = ($urandom_range(0, 3) == 0) ? 5'd8 : 5'd7;
            alarm_enable = ($urandom_range(0, 79) != 0);
            t = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 29) == 0);
            step(t, s, d);
            n_vec++;
            if (alarm_on !== (m_mode == MD_RING) || snoozed !== (m_mode == MD_NAP) ||
                snooze_count !== 3'(m_cnt)) begin
                $display("FAIL random_cycle_%0d: on=%b snz=%b cnt=%0d, want %b/%b/%0d", i,
                         alarm_on, snoozed, snooze_count, (m_mode == MD_RING), (m_mode == MD_NAP), m_cnt);
                n_bad++;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_basic_ring();
        test_snooze_limit();
        test_dismiss_vs_snooze();
        test_tick_with_snooze();
        test_disable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
